// File: rtl/computer_run_ctrl_if.sv
// Control/status bundle between the top level (master) and the run controller (slave).
interface computer_run_ctrl_if #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int CYCLE_W = 32
);
  logic               load_start;
  logic               ld_valid;
  logic [DATA_W-1:0]  ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               cmd_run;
  logic               cmd_halt;
  logic               cmd_step;
  logic               bp_en;
  logic [ADDR_W-1:0]  bp_addr;
  logic [ADDR_W-1:0]  pc;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               cpu_reset;
  logic               cpu_en;
  logic [2:0]         state;
  logic               halted;
  logic               bp_hit;
  logic               load_ovf;
  logic [CYCLE_W-1:0] cycle_count;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, cmd_run, cmd_halt, cmd_step,
           bp_en, bp_addr, pc,
    input  ld_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_en,
           state, halted, bp_hit, load_ovf, cycle_count
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, cmd_run, cmd_halt, cmd_step,
           bp_en, bp_addr, pc,
    output ld_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_en,
           state, halted, bp_hit, load_ovf, cycle_count
  );
endinterface

// File: rtl/computer_run_ctrl.sv
// Hack run/debug controller: loads instruction memory, then gates the CPU for run/halt/step/breakpoint.
// Outputs decode from state; imem_we, ld_ready and the breakpoint cpu_en drop are same-cycle.
module computer_run_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int CYCLE_W = 32
) (
  input logic                i_clk_in,
  input logic                i_reset,
  computer_run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_HALT = 3'd3,
    S_RUN  = 3'd4,
    S_STEP = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_W-1:0] CYCLE_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_waddr, w_waddr_nxt;
  logic               r_clr_to_run, w_clr_to_run_nxt;
  logic               r_resume, w_resume_nxt;
  logic               r_bp_hit, w_bp_hit_nxt;
  logic               r_load_ovf, w_load_ovf_nxt;
  logic [CYCLE_W-1:0] r_cycle;
  logic               w_cpu_en, w_cpu_reset, w_ld_ready, w_imem_we, w_clear_cnt;
  logic               w_bp_match, w_waddr_top;

  assign w_bp_match  = bus.bp_en && (bus.pc == bus.bp_addr);
  assign w_waddr_top = (r_waddr == {ADDR_W{1'b1}});

  always_comb begin
    w_state_nxt      = r_state;
    w_waddr_nxt      = r_waddr;
    w_clr_to_run_nxt = r_clr_to_run;
    w_resume_nxt     = 1'b0;
    w_bp_hit_nxt     = r_bp_hit;
    w_load_ovf_nxt   = r_load_ovf;
    w_cpu_en         = 1'b0;
    w_cpu_reset      = 1'b0;
    w_ld_ready       = 1'b0;
    w_imem_we        = 1'b0;
    w_clear_cnt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cpu_reset = 1'b1;
        if (bus.load_start) begin
          w_state_nxt    = S_LOAD;
          w_waddr_nxt    = '0;
          w_load_ovf_nxt = 1'b0;
        end else if (bus.cmd_run) begin
          w_state_nxt      = S_CLR;
          w_clr_to_run_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        w_cpu_reset = 1'b1;
        w_ld_ready  = 1'b1;
        w_imem_we   = bus.ld_valid;
        if (bus.ld_valid) begin
          // The address counter saturates at the top so a runaway load never overwrites word 0.
          if (!w_waddr_top) w_waddr_nxt = r_waddr + ADDR_ONE;
          if (bus.ld_last) begin
            w_state_nxt      = S_CLR;
            w_clr_to_run_nxt = 1'b0;
          end else if (w_waddr_top) begin
            w_state_nxt      = S_CLR;
            w_clr_to_run_nxt = 1'b0;
            w_load_ovf_nxt   = 1'b1;
          end
        end
      end
      S_CLR: begin
        w_cpu_reset  = 1'b1;
        w_cpu_en     = 1'b1;
        w_clear_cnt  = 1'b1;
        w_bp_hit_nxt = 1'b0;
        w_state_nxt  = r_clr_to_run ? S_RUN : S_HALT;
      end
      S_HALT: begin
        if (bus.load_start) begin
          w_state_nxt    = S_LOAD;
          w_waddr_nxt    = '0;
          w_load_ovf_nxt = 1'b0;
        end else if (bus.cmd_step) begin
          w_state_nxt = S_STEP;
        end else if (bus.cmd_run) begin
          w_state_nxt  = S_RUN;
          w_resume_nxt = 1'b1;
        end
      end
      S_STEP: begin
        w_cpu_en    = 1'b1;
        w_state_nxt = S_HALT;
      end
      S_RUN: begin
        w_cpu_en = 1'b1;
        // First cycle after resuming from HALT ignores the breakpoint so execution can leave bp_addr.
        if (bus.cmd_halt) begin
          w_state_nxt = S_HALT;
        end else if (w_bp_match && !r_resume) begin
          w_cpu_en     = 1'b0;
          w_bp_hit_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_waddr      <= '0;
      r_clr_to_run <= 1'b0;
      r_resume     <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_load_ovf   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_waddr      <= w_waddr_nxt;
      r_clr_to_run <= w_clr_to_run_nxt;
      r_resume     <= w_resume_nxt;
      r_bp_hit     <= w_bp_hit_nxt;
      r_load_ovf   <= w_load_ovf_nxt;
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (i_reset || w_clear_cnt) begin
      r_cycle <= '0;
    end else if (w_cpu_en && !w_cpu_reset && (r_cycle != {CYCLE_W{1'b1}})) begin
      r_cycle <= r_cycle + CYCLE_ONE;
    end
  end

  assign bus.ld_ready    = w_ld_ready;
  assign bus.imem_we     = w_imem_we;
  assign bus.imem_waddr  = r_waddr;
  assign bus.imem_wdata  = bus.ld_data;
  assign bus.cpu_reset   = w_cpu_reset;
  assign bus.cpu_en      = w_cpu_en;
  assign bus.state       = r_state;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.bp_hit      = r_bp_hit;
  assign bus.load_ovf    = r_load_ovf;
  assign bus.cycle_count = r_cycle;
endmodule
